bomb_sprite_ctrl: RTL and testbench
===================================

Name: bomb_sprite_ctrl

Overview:
- Bomb lifecycle controller and pixel gate, directly upstream of the 16x16 bomb sprite mask.
- Accepts one bomb placement on the 16-pixel tile grid and runs the fuse (with end-of-fuse blink) and the blast phase, counted in video frames.
- Per scan pixel: drives the mask's local coordinates, consumes its 3-bit colour, and emits registered bomb-draw and blast-draw enables for the pixel mux.
- One bomb in flight at a time.

Parameters:
- FUSE_FRAMES, 180, frame ticks from placement to explosion (1..255)
- BLINK_FRAMES, 60, final fuse frames during which the sprite blinks (0..FUSE_FRAMES-1)
- BLAST_FRAMES, 30, frame ticks the blast stays active (1..255)
- RANGE, 2, blast arm length in tiles each direction (0..7)
- MAP_W, 40, map width in tiles
- MAP_H, 30, map height in tiles

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-cycle pulse per frame
- place_req, in, 1, request to place a bomb (sampled each cycle)
- place_tx, in, 6, requested tile column
- place_ty, in, 5, requested tile row
- place_ack, out, 1, one-cycle pulse: placement accepted
- px, in, 10, scan x
- py, in, 10, scan y
- video_on, in, 1, active-video qualifier for px/py
- mask_px, out, 10, x to the sprite mask (registered px)
- mask_py, out, 10, y to the sprite mask (registered py)
- mask_col, in, 3, colour returned by the sprite mask, combinational on mask_px/mask_py
- bomb_draw, out, 1, draw bomb pixel
- bomb_rgb, out, 3, colour for bomb pixel (0 when bomb_draw=0)
- blast_draw, out, 1, pixel lies in the active blast cross
- busy, out, 1, state != IDLE
- exploding, out, 1, state == EXPLODE
- explode_pulse, out, 1, one-cycle pulse on the ARMED->EXPLODE transition
- bomb_tx, out, 6, latched bomb tile column
- bomb_ty, out, 5, latched bomb tile row

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; all outputs 0; counter 0; blink_vis 1.
  - Reset mid-fuse or mid-blast aborts immediately.
- State machine: IDLE, ARMED, EXPLODE.
- IDLE:
  - place_req=1 with place_tx<MAP_W and place_ty<MAP_H: latch tile, cnt<=FUSE_FRAMES, blink_vis<=1, place_ack=1 next cycle, go ARMED.
  - Out-of-range request: ignored, no ack.
- ARMED:
  - place_req is ignored (no ack, latched tile unchanged).
  - On frame_tick with cnt==1: cnt<=BLAST_FRAMES, explode_pulse=1 next cycle, go EXPLODE.
  - On any other frame_tick: cnt<=cnt-1.
  - On frame_tick with cnt<=BLINK_FRAMES: blink_vis toggles.
  - Net effect: ARMED lasts exactly FUSE_FRAMES ticks after acceptance.
- EXPLODE:
  - On frame_tick with cnt==1: go IDLE.
  - On any other frame_tick: decrement cnt.
  - place_req is ignored.
- frame_tick in the same cycle as an accepted placement: placement wins; no decrement that cycle.
- cnt is 8 bits and never wraps; decrement happens only when cnt>1.
- Pixel pipeline, 2-cycle latency from px/py to draw outputs:
  - Stage 1 registers px, py and video_on; mask_px/mask_py are these registers.
  - Tile coordinates: ptx=mask_px[9:4], pty=mask_py[9:4].
  - Stage 2 registers the outputs:
    - bomb_draw = v1 & ARMED & blink_vis & ptx==bomb_tx & pty==bomb_ty & mask_col!=0
    - bomb_rgb = bomb_draw ? mask_col : 0
    - blast_draw = v1 & EXPLODE & ptx<MAP_W & pty<MAP_H & ((pty==bomb_ty & |ptx-bomb_tx|<=RANGE) | (ptx==bomb_tx & |pty-bomb_ty|<=RANGE))
  - Differences are computed unsigned as max-min, so no sign wrap at map edges.
  - Cross arms clip naturally at tile 0 and at MAP_W-1/MAP_H-1.
- State and counter updates do not stall the pixel pipeline. A state change appears on draw outputs for pixels entering stage 1 on or after the change cycle.

Test Plan (FUSE_FRAMES=4, BLINK_FRAMES=2, BLAST_FRAMES=2, RANGE=1):
- Reset then place_req tx=5 ty=3 -> place_ack pulse 1 cycle later; busy=1; bomb_tx=5, bomb_ty=3; after 4 frame_ticks explode_pulse once and exploding=1; after 2 more ticks busy=0.
- While ARMED, place_req tx=9 ty=9 -> no ack, bomb_tx stays 5; out-of-range request in IDLE (tx=40) -> no ack, busy=0.
- Scan px=80..95, py=48..63 with mask_col=3'b001 at px=84 -> bomb_draw=1 and bomb_rgb=001 two cycles after px=84; pixel at px=96 -> bomb_draw=0.
- Blink: ticks 1..4 after placement -> blink_vis 1,1,0,1; bomb_draw suppressed only during the blink_vis=0 frame.
- Bomb at tile 0,0 in EXPLODE -> blast_draw=1 for tiles (0,0), (1,0), (0,1); 0 for (2,0), (1,1), (39,0); 0 when video_on=0.
- Assert rst_n low mid-EXPLODE -> all outputs 0 immediately (asynchronous); after release, a new placement is accepted normally.

Source files
------------

// File: rtl/bomb_sprite_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bomb_sprite_ctrl_if
// Brief    : Bomb placement handshake: requested tile plus one-cycle accept.
// Revision : 1.0 - initial release
// ============================================================================
interface bomb_sprite_ctrl_if;
    logic       place_req;
    logic [5:0] place_tx;
    logic [4:0] place_ty;
    logic       place_ack;

    // Game logic side: issues placement requests, receives the accept pulse
    modport master (
        output place_req,
        output place_tx,
        output place_ty,
        input  place_ack
    );

    // Bomb controller side
    modport slave (
        input  place_req,
        input  place_tx,
        input  place_ty,
        output place_ack
    );
endinterface
`default_nettype wire

// File: rtl/bomb_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomb_sprite_ctrl
// Brief    : Single-bomb lifecycle (fuse with end blink, blast) counted in
//            frames, plus a 2-stage pixel gate producing bomb-draw and
//            blast-cross enables in front of the 16x16 bomb sprite mask.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_sprite_ctrl #(
    parameter int FUSE_FRAMES  = 180,
    parameter int BLINK_FRAMES = 60,
    parameter int BLAST_FRAMES = 30,
    parameter int RANGE        = 2,
    parameter int MAP_W        = 40,
    parameter int MAP_H        = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    bomb_sprite_ctrl_if.slave        place,
    input  logic [9:0]               px,
    input  logic [9:0]               py,
    input  logic                     video_on,
    output logic [9:0]               mask_px,
    output logic [9:0]               mask_py,
    input  logic [2:0]               mask_col,
    output logic                     bomb_draw,
    output logic [2:0]               bomb_rgb,
    output logic                     blast_draw,
    output logic                     busy,
    output logic                     exploding,
    output logic                     explode_pulse,
    output logic [5:0]               bomb_tx,
    output logic [4:0]               bomb_ty
);

    localparam logic [7:0] c_fuse  = 8'(FUSE_FRAMES);
    localparam logic [7:0] c_blink = 8'(BLINK_FRAMES);
    localparam logic [7:0] c_blast = 8'(BLAST_FRAMES);
    localparam logic [5:0] c_range = 6'(RANGE);
    localparam logic [6:0] c_map_w = 7'(MAP_W);
    localparam logic [6:0] c_map_h = 7'(MAP_H);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_EXPLODE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_blink_vis, w_blink_nxt;
    logic [5:0] r_bomb_tx, w_tx_nxt;
    logic [4:0] r_bomb_ty, w_ty_nxt;
    logic       r_ack, w_ack_nxt;
    logic       r_xpl, w_xpl_nxt;
    logic       w_place_ok;

    // Pixel pipeline registers
    logic [9:0] r_px1, r_py1;
    logic       r_v1;
    logic       r_bomb_draw, r_blast_draw;
    logic [2:0] r_bomb_rgb;

    logic [5:0] w_ptx, w_pty, w_by6, w_dx, w_dy;
    logic       w_in_map, w_bomb_nxt, w_blast_nxt;

    assign w_place_ok = place.place_req
                        && ({1'b0, place.place_tx} < c_map_w)
                        && ({2'b0, place.place_ty} < c_map_h);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter, blink and pulse decode; placement beats frame_tick
    // because IDLE never looks at the tick
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_blink_nxt = r_blink_vis;
        w_tx_nxt    = r_bomb_tx;
        w_ty_nxt    = r_bomb_ty;
        w_ack_nxt   = 1'b0;
        w_xpl_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_place_ok) begin
                    w_state_nxt = S_ARMED;
                    w_tx_nxt    = place.place_tx;
                    w_ty_nxt    = place.place_ty;
                    w_cnt_nxt   = c_fuse;
                    w_blink_nxt = 1'b1;
                    w_ack_nxt   = 1'b1;
                end
            end
            S_ARMED: begin
                if (frame_tick) begin
                    if (r_cnt <= c_blink) begin
                        w_blink_nxt = ~r_blink_vis;
                    end
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_EXPLODE;
                        w_cnt_nxt   = c_blast;
                        w_xpl_nxt   = 1'b1;
                    end else if (r_cnt > 8'd1) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            S_EXPLODE: begin
                if (frame_tick) begin
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt > 8'd1) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lifecycle data registers: counter, blink phase, latched tile, pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 8'd0;
            r_blink_vis <= 1'b1;
            r_bomb_tx   <= 6'd0;
            r_bomb_ty   <= 5'd0;
            r_ack       <= 1'b0;
            r_xpl       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_blink_vis <= w_blink_nxt;
            r_bomb_tx   <= w_tx_nxt;
            r_bomb_ty   <= w_ty_nxt;
            r_ack       <= w_ack_nxt;
            r_xpl       <= w_xpl_nxt;
        end
    end

    // Tile-space distances taken as max-min so the cross never wraps at edges
    assign w_ptx    = r_px1[9:4];
    assign w_pty    = r_py1[9:4];
    assign w_by6    = {1'b0, r_bomb_ty};
    assign w_dx     = (w_ptx >= r_bomb_tx) ? (w_ptx - r_bomb_tx) : (r_bomb_tx - w_ptx);
    assign w_dy     = (w_pty >= w_by6) ? (w_pty - w_by6) : (w_by6 - w_pty);
    assign w_in_map = ({1'b0, w_ptx} < c_map_w) && ({1'b0, w_pty} < c_map_h);

    assign w_bomb_nxt  = r_v1 && (r_state == S_ARMED) && r_blink_vis
                         && (w_ptx == r_bomb_tx) && (w_pty == w_by6)
                         && (mask_col != 3'd0);
    assign w_blast_nxt = r_v1 && (r_state == S_EXPLODE) && w_in_map
                         && (((w_pty == w_by6) && (w_dx <= c_range))
                          || ((w_ptx == r_bomb_tx) && (w_dy <= c_range)));

    // Stage 1: capture scan position; these registers address the sprite mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px1 <= 10'd0;
            r_py1 <= 10'd0;
            r_v1  <= 1'b0;
        end else begin
            r_px1 <= px;
            r_py1 <= py;
            r_v1  <= video_on;
        end
    end

    // Stage 2: register the draw enables and the gated colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bomb_draw  <= 1'b0;
            r_bomb_rgb   <= 3'd0;
            r_blast_draw <= 1'b0;
        end else begin
            r_bomb_draw  <= w_bomb_nxt;
            r_bomb_rgb   <= w_bomb_nxt ? mask_col : 3'd0;
            r_blast_draw <= w_blast_nxt;
        end
    end

    assign place.place_ack = r_ack;
    assign mask_px         = r_px1;
    assign mask_py         = r_py1;
    assign bomb_draw       = r_bomb_draw;
    assign bomb_rgb        = r_bomb_rgb;
    assign blast_draw      = r_blast_draw;
    assign busy            = (r_state != S_IDLE);
    assign exploding       = (r_state == S_EXPLODE);
    assign explode_pulse   = r_xpl;
    assign bomb_tx         = r_bomb_tx;
    assign bomb_ty         = r_bomb_ty;

endmodule
`default_nettype wire

// File: tb/tb_bomb_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_sprite_ctrl
// Brief    : Directed, table-driven bench for bomb_sprite_ctrl
//            (FUSE=4, BLINK=2, BLAST=2, RANGE=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bomb_sprite_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic [9:0] px, py;
    logic       video_on;
    logic [9:0] mask_px, mask_py;
    logic [2:0] mask_col;
    logic       bomb_draw, blast_draw, busy, exploding, explode_pulse;
    logic [2:0] bomb_rgb;
    logic [5:0] bomb_tx;
    logic [4:0] bomb_ty;

    // Sprite mask model: returns the vector's colour only when the mask is
    // addressed with the pixel currently under test
    logic [9:0] cur_px, cur_py;
    logic [2:0] hot_col;
    assign mask_col = (mask_px == cur_px && mask_py == cur_py) ? hot_col : 3'd0;

    bomb_sprite_ctrl_if pif ();

    bomb_sprite_ctrl #(
        .FUSE_FRAMES  (4),
        .BLINK_FRAMES (2),
        .BLAST_FRAMES (2),
        .RANGE        (1),
        .MAP_W        (40),
        .MAP_H        (30)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .place         (pif),
        .px            (px),
        .py            (py),
        .video_on      (video_on),
        .mask_px       (mask_px),
        .mask_py       (mask_py),
        .mask_col      (mask_col),
        .bomb_draw     (bomb_draw),
        .bomb_rgb      (bomb_rgb),
        .blast_draw    (blast_draw),
        .busy          (busy),
        .exploding     (exploding),
        .explode_pulse (explode_pulse),
        .bomb_tx       (bomb_tx),
        .bomb_ty       (bomb_ty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       phase;   // 0: bomb ARMED at (5,3); 1: EXPLODE at (0,0)
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
        logic [2:0] col;
        logic       e_bomb;
        logic [2:0] e_rgb;
        logic       e_blast;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_vec;
    int n_fail;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic place_bomb(input logic [5:0] tx, input logic [4:0] ty);
        pif.place_req = 1'b1;
        pif.place_tx  = tx;
        pif.place_ty  = ty;
        step();
        pif.place_req = 1'b0;
    endtask

    task automatic apply_pix(input logic [9:0] x, input logic [9:0] y,
                             input logic v, input logic [2:0] col);
        px      = x;
        py      = y;
        video_on = v;
        cur_px  = x;
        cur_py  = y;
        hot_col = col;
        step();
        step();
    endtask

    task automatic run_phase(input logic ph);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == ph) begin
                apply_pix(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].col);
                check($sformatf("vec%0d bomb_draw", i), 32'(bomb_draw), 32'(vecs[i].e_bomb));
                check($sformatf("vec%0d bomb_rgb", i), 32'(bomb_rgb), 32'(vecs[i].e_rgb));
                check($sformatf("vec%0d blast_draw", i), 32'(blast_draw), 32'(vecs[i].e_blast));
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Bomb at tile (5,3): tile spans px 80..95, py 48..63
        vecs[0]  = '{1'b0, 10'd84,  10'd50, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 10'd84,  10'd50, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 10'd96,  10'd50, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 10'd80,  10'd48, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 10'd95,  10'd63, 1'b1, 3'd7, 1'b1, 3'd7, 1'b0};
        vecs[5]  = '{1'b0, 10'd84,  10'd64, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 10'd79,  10'd50, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0};
        // Bomb at tile (0,0) exploding, RANGE=1
        vecs[7]  = '{1'b1, 10'd8,   10'd8,  1'b1, 3'd1, 1'b0, 3'd0, 1'b1};
        vecs[8]  = '{1'b1, 10'd19,  10'd2,  1'b1, 3'd1, 1'b0, 3'd0, 1'b1};
        vecs[9]  = '{1'b1, 10'd5,   10'd20, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1};
        vecs[10] = '{1'b1, 10'd32,  10'd4,  1'b1, 3'd1, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{1'b1, 10'd20,  10'd20, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{1'b1, 10'd625, 10'd3,  1'b1, 3'd1, 1'b0, 3'd0, 1'b0};
        vecs[13] = '{1'b1, 10'd8,   10'd8,  1'b0, 3'd1, 1'b0, 3'd0, 1'b0};
        vecs[14] = '{1'b1, 10'd2,   10'd465, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0};

        rst_n         = 1'b0;
        frame_tick    = 1'b0;
        pif.place_req = 1'b0;
        pif.place_tx  = 6'd0;
        pif.place_ty  = 5'd0;
        px            = 10'd300;
        py            = 10'd200;
        video_on      = 1'b1;
        cur_px        = 10'd0;
        cur_py        = 10'd0;
        hot_col       = 3'd0;

        // Reset state
        step(); step(); step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset mask_px", 32'(mask_px), 32'd0);
        check("reset bomb_tx", 32'(bomb_tx), 32'd0);
        check("reset place_ack", 32'(pif.place_ack), 32'd0);
        rst_n = 1'b1;
        step();

        // Out-of-range requests in IDLE are dropped
        place_bomb(6'd40, 5'd3);
        step();
        check("oor tx ack", 32'(pif.place_ack), 32'd0);
        check("oor tx busy", 32'(busy), 32'd0);
        place_bomb(6'd2, 5'd30);
        step();
        check("oor ty ack", 32'(pif.place_ack), 32'd0);
        check("oor ty busy", 32'(busy), 32'd0);

        // Accepted placement
        place_bomb(6'd5, 5'd3);
        check("place ack", 32'(pif.place_ack), 32'd1);
        check("place busy", 32'(busy), 32'd1);
        check("place bomb_tx", 32'(bomb_tx), 32'd5);
        check("place bomb_ty", 32'(bomb_ty), 32'd3);
        step();
        check("ack one cycle", 32'(pif.place_ack), 32'd0);

        // Second request while ARMED is ignored
        place_bomb(6'd9, 5'd9);
        check("armed req ack", 32'(pif.place_ack), 32'd0);
        step();
        check("armed req ack2", 32'(pif.place_ack), 32'd0);
        check("armed req tx", 32'(bomb_tx), 32'd5);
        check("armed req ty", 32'(bomb_ty), 32'd3);

        run_phase(1'b0);

        // Fuse: blink_vis 1,1,0 after ticks 1..3, explode on tick 4
        for (int t = 1; t <= 3; t++) begin
            tick();
            check($sformatf("tick%0d exploding", t), 32'(exploding), 32'd0);
            check($sformatf("tick%0d pulse", t), 32'(explode_pulse), 32'd0);
            apply_pix(10'd84, 10'd50, 1'b1, 3'd1);
            check($sformatf("tick%0d blink draw", t), 32'(bomb_draw), (t == 3) ? 32'd0 : 32'd1);
        end
        tick();
        check("tick4 pulse", 32'(explode_pulse), 32'd1);
        check("tick4 exploding", 32'(exploding), 32'd1);
        step();
        check("pulse one cycle", 32'(explode_pulse), 32'd0);
        apply_pix(10'd84, 10'd50, 1'b1, 3'd1);
        check("explode no bomb", 32'(bomb_draw), 32'd0);
        check("explode centre", 32'(blast_draw), 32'd1);
        apply_pix(10'd115, 10'd50, 1'b1, 3'd0);
        check("explode range", 32'(blast_draw), 32'd0);

        // Blast lasts two ticks
        tick();
        check("blast tick1 busy", 32'(busy), 32'd1);
        tick();
        check("blast tick2 busy", 32'(busy), 32'd0);
        check("blast tick2 expl", 32'(exploding), 32'd0);

        // Corner bomb at (0,0); frame_tick coinciding with placement is ignored
        frame_tick = 1'b1;
        place_bomb(6'd0, 5'd0);
        frame_tick = 1'b0;
        check("corner ack", 32'(pif.place_ack), 32'd1);
        for (int t = 1; t <= 3; t++) begin
            tick();
        end
        check("corner still armed", 32'(exploding), 32'd0);
        tick();
        check("corner exploding", 32'(exploding), 32'd1);
        run_phase(1'b1);

        // Asynchronous reset mid-blast
        apply_pix(10'd8, 10'd8, 1'b1, 3'd0);
        check("pre-reset blast", 32'(blast_draw), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst blast", 32'(blast_draw), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst exploding", 32'(exploding), 32'd0);
        check("async rst mask_px", 32'(mask_px), 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        place_bomb(6'd7, 5'd2);
        check("post-rst ack", 32'(pif.place_ack), 32'd1);
        check("post-rst tx", 32'(bomb_tx), 32'd7);
        check("post-rst ty", 32'(bomb_ty), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
